// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the fetch-stage state encoding.
package pipeline_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8002_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } ifetch_state_t;

endpackage

// File: rtl/ifetch_perf_cnt.sv
// Saturating 32-bit event counter for fetch-stage statistics.
// Only compiled when IFETCH_PERF_EN is defined.
`ifdef IFETCH_PERF_EN
module ifetch_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= 32'h0;
        else if (inc && count != 32'hFFFF_FFFF)
            count <= count + 32'h1;
    end

endmodule
`endif

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC register, imem handshake, hold buffer for stalls, redirect drain.
// IFETCH_PERF_EN adds perf_fetched / perf_stall_cyc counters.
module ifetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] ir_out,
    output logic        valid_out
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cyc
`endif
);

    ifetch_state_t state, state_n;
    logic [31:0]   pc_reg, pc_n;
    logic [31:0]   drain_addr, drain_n;
    logic [31:0]   hold_pc, hold_pc_n;
    logic [31:0]   hold_ir, hold_ir_n;
    logic [31:0]   pc_out_n, ir_out_n;
    logic          valid_n;

    assign imem_req  = (state != HOLD);
    assign imem_addr = (state == DRAIN) ? drain_addr : pc_reg;

    always_comb begin
        state_n   = state;
        pc_n      = pc_reg;
        drain_n   = drain_addr;
        hold_pc_n = hold_pc;
        hold_ir_n = hold_ir;
        pc_out_n  = pc_out;
        ir_out_n  = ir_out;
        valid_n   = valid_out;
        if (redirect_valid) begin
            pc_n      = redirect_pc & ~32'h3;
            valid_n   = 1'b0;
            hold_pc_n = 32'h0;
            hold_ir_n = NOP_INSTR;
            case (state)
                // An unacked request is still owned by imem; its response must be swallowed.
                REQ: begin
                    if (!imem_ack) begin
                        state_n = DRAIN;
                        drain_n = pc_reg;
                    end
                end
                HOLD:    state_n = REQ;
                DRAIN:   state_n = DRAIN;
                default: state_n = REQ;
            endcase
        end else begin
            case (state)
                REQ: begin
                    if (imem_ack) begin
                        if (stall) begin
                            hold_pc_n = pc_reg;
                            hold_ir_n = imem_rdata;
                            state_n   = HOLD;
                        end else begin
                            pc_out_n = pc_reg;
                            ir_out_n = imem_rdata;
                            valid_n  = 1'b1;
                            pc_n     = pc_reg + PC_STEP;
                        end
                    end else if (!stall) begin
                        valid_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc_out_n = hold_pc;
                        ir_out_n = hold_ir;
                        valid_n  = 1'b1;
                        pc_n     = pc_reg + PC_STEP;
                        state_n  = REQ;
                    end
                end
                DRAIN: begin
                    if (imem_ack)
                        state_n = REQ;
                end
                default: state_n = REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= REQ;
            pc_reg     <= RESET_PC;
            drain_addr <= 32'h0;
            hold_pc    <= 32'h0;
            hold_ir    <= NOP_INSTR;
            pc_out     <= 32'h0;
            ir_out     <= NOP_INSTR;
            valid_out  <= 1'b0;
        end else begin
            state      <= state_n;
            pc_reg     <= pc_n;
            drain_addr <= drain_n;
            hold_pc    <= hold_pc_n;
            hold_ir    <= hold_ir_n;
            pc_out     <= pc_out_n;
            ir_out     <= ir_out_n;
            valid_out  <= valid_n;
        end
    end

`ifdef IFETCH_PERF_EN
    logic present;

    // Counts each edge that loads a real instruction into the outputs.
    assign present = !redirect_valid && !stall &&
                     ((state == REQ && imem_ack) || state == HOLD);

    ifetch_perf_cnt u_fetched_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (present),
        .count (perf_fetched)
    );

    ifetch_perf_cnt u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall),
        .count (perf_stall_cyc)
    );
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed scenarios plus random stall/ack/redirect traffic checked against a behavioural fetch model.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ack_en = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out, ir_out;
    logic        valid_out;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall_cyc;
`endif

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    assign imem_ack   = ack_en & imem_req;
    assign imem_rdata = mem_word(imem_addr);

    ifetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .pc_out         (pc_out),
        .ir_out         (ir_out),
        .valid_out      (valid_out)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall_cyc (perf_stall_cyc)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: next PC to fetch, an optional parked word, and an optional
    // abandoned address whose response is still owed by memory.
    logic [31:0] m_pc, m_out_pc, m_out_ir, m_buf_pc, m_buf_ir, m_drain_addr;
    logic        m_valid, m_has_buf, m_draining;
    logic [31:0] m_fetched, m_stalls;

    function automatic logic m_req();
        return !m_has_buf;
    endfunction

    function automatic logic [31:0] m_addr();
        return m_draining ? m_drain_addr : m_pc;
    endfunction

    always @(posedge clk) begin
        logic got_word;
        if (rst) begin
            m_pc = 32'h8002_0000; m_has_buf = 0; m_draining = 0;
            m_out_pc = 0; m_out_ir = 0; m_valid = 0;
            m_fetched = 0; m_stalls = 0;
        end else begin
            got_word = ack_en && m_req();
            if (stall && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
            if (redirect_valid) begin
                if (!m_draining && !m_has_buf && !got_word) begin
                    m_draining = 1;
                    m_drain_addr = m_pc;
                end
                m_has_buf = 0;
                m_valid = 0;
                m_pc = {redirect_pc[31:2], 2'b00};
            end else if (m_draining) begin
                if (got_word) m_draining = 0;
            end else if (m_has_buf) begin
                if (!stall) begin
                    m_out_pc = m_buf_pc; m_out_ir = m_buf_ir; m_valid = 1;
                    m_pc = m_pc + 4; m_has_buf = 0;
                    if (m_fetched != 32'hFFFF_FFFF) m_fetched = m_fetched + 1;
                end
            end else if (got_word) begin
                if (stall) begin
                    m_has_buf = 1; m_buf_pc = m_pc; m_buf_ir = mem_word(m_pc);
                end else begin
                    m_out_pc = m_pc; m_out_ir = mem_word(m_pc); m_valid = 1;
                    m_pc = m_pc + 4;
                    if (m_fetched != 32'hFFFF_FFFF) m_fetched = m_fetched + 1;
                end
            end else if (!stall) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid_out", {31'h0, valid_out}, {31'h0, m_valid});
            chk("pc_out", pc_out, m_out_pc);
            chk("ir_out", ir_out, m_out_ir);
            chk("imem_req", {31'h0, imem_req}, {31'h0, m_req()});
            if (m_req()) chk("imem_addr", imem_addr, m_addr());
`ifdef IFETCH_PERF_EN
            chk("perf_fetched", perf_fetched, m_fetched);
            chk("perf_stall_cyc", perf_stall_cyc, m_stalls);
`endif
        end
    end

    task automatic step(input bit s, input bit r, input logic [31:0] rp, input bit a);
        stall = s; redirect_valid = r; redirect_pc = rp; ack_en = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk_en = 1'b1;
        chk("rst valid", {31'h0, valid_out}, 32'h0);
        chk("rst pc_out", pc_out, 32'h0);
        chk("rst ir_out", ir_out, 32'h0);
        chk("rst addr", imem_addr, 32'h8002_0000);
        rst = 1'b0;

        // zero-wait memory: one instruction per edge
        step(0, 0, 0, 1); chk("zw pc0", pc_out, 32'h8002_0000);
        chk("zw valid", {31'h0, valid_out}, 32'h1);
        step(0, 0, 0, 1); chk("zw pc1", pc_out, 32'h8002_0004);
        step(0, 0, 0, 1); chk("zw pc2", pc_out, 32'h8002_0008);
        chk("zw ir2", ir_out, mem_word(32'h8002_0008));

        // ack every third cycle
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0);
            chk("slow bubble", {31'h0, valid_out}, 32'h0);
            step(0, 0, 0, 0);
            chk("slow addr held", imem_addr, 32'h8002_000C + 32'(4 * k));
            step(0, 0, 0, 1);
            chk("slow pc", pc_out, 32'h8002_000C + 32'(4 * k));
        end

        // stall during ack parks the word
        step(1, 0, 0, 1);
        chk("hold pc frozen", pc_out, 32'h8002_0014);
        chk("hold req", {31'h0, imem_req}, 32'h0);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 1);
        chk("hold still", pc_out, 32'h8002_0014);
        step(0, 0, 0, 0);
        chk("hold release pc", pc_out, 32'h8002_0018);
        chk("hold release ir", ir_out, mem_word(32'h8002_0018));

        // redirect while request outstanding
        step(0, 1, 32'h8002_0103, 0);
        chk("drain valid", {31'h0, valid_out}, 32'h0);
        chk("drain addr", imem_addr, 32'h8002_001C);
        step(0, 0, 0, 0);
        chk("drain addr held", imem_addr, 32'h8002_001C);
        step(0, 0, 0, 1);
        chk("drain discard", {31'h0, valid_out}, 32'h0);
        chk("refetch addr", imem_addr, 32'h8002_0100);
        step(0, 0, 0, 1);
        chk("refetch pc", pc_out, 32'h8002_0100);

        // PC wrap
        step(0, 1, 32'hFFFF_FFFC, 1);
        chk("wrap addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 1);
        chk("wrap pc", pc_out, 32'hFFFF_FFFC);
        chk("wrap next", imem_addr, 32'h0);

        // reset mid-drain with stall
        step(0, 1, 32'h8002_0200, 0);
        rst = 1'b1;
        step(1, 0, 0, 0);
        chk("rst drain valid", {31'h0, valid_out}, 32'h0);
        chk("rst drain addr", imem_addr, 32'h8002_0000);
        chk("rst drain req", {31'h0, imem_req}, 32'h1);
`ifdef IFETCH_PERF_EN
        chk("rst perf f", perf_fetched, 32'h0);
        chk("rst perf s", perf_stall_cyc, 32'h0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            logic [31:0] rp;
            rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom;
            rst = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, rp,
                 $urandom_range(0, 1) == 1);
        end
        rst = 1'b0;
        step(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
